// File: rtl/mux_sync_pkg.sv
// ---------------------------------------------------------------------------
// mux_sync_pkg
// Shared definitions for the mux-recirculation synchronizer family: the
// launcher FSM state encoding and the default data width / timing constants,
// so the launcher, the synchronizer and their benches all agree.
// ---------------------------------------------------------------------------
package mux_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam int DEF_DW           = 8;
    localparam int DEF_HOLD_CYCLES  = 9;   // 3 clkb periods at 1:3 clka:clkb
    localparam int DEF_GUARD_CYCLES = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mux_sync_launcher_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Plain 1-bit two-flop level synchronizer. Used by the launcher to bring the
// destination acknowledge into clka; equally usable on the destination side.
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset (output resets to 0)
//   d    in  asynchronous level
//   q    out synchronized level, two clk edges of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture; the first stage may go metastable, the second filters it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/mux_sync_launcher.sv
// ---------------------------------------------------------------------------
// mux_sync_launcher
// clka-side launcher feeding a mux-recirculation N-flop synchronizer. Accepts
// a word over valid/ready, then raises en for HOLD_CYCLES clka cycles and
// keeps data frozen for GUARD_CYCLES more so the slower clkb side never sees
// data move while en (or its synchronized copy) may still be in flight.
//
// Optional feature macro: MUX_LAUNCH_ACK_EN
//   When defined, ack_b (clkb level) is synchronized into clka and the
//   count-based exits additionally wait for ack high (HOLD) and ack low
//   (GUARD), forming a 4-phase handshake.
//
// Ports:
//   clka      in   source clock
//   rsta      in   asynchronous active-high reset
//   in_valid  in   upstream word valid
//   in_ready  out  launcher can accept (IDLE and not in reset)
//   in_data   in   upstream word [DW-1:0]
//   en        out  registered enable to the synchronizer
//   data      out  registered data to the synchronizer [DW-1:0]
//   busy      out  registered, high whenever state != IDLE
//   ack_b     in   destination acknowledge level (only with MUX_LAUNCH_ACK_EN)
// ---------------------------------------------------------------------------
module mux_sync_launcher
    import mux_sync_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    localparam int CNT_W       = $clog2(max_int(HOLD_CYCLES, GUARD_CYCLES) + 1)
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          en,
    output logic [DW-1:0] data,
`ifdef MUX_LAUNCH_ACK_EN
    input  logic          ack_b,
`endif
    output logic          busy
);

    // Reload values; GUARD reload is clamped so a zero guard never underflows.
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             en_nx_s;
    logic [DW-1:0]    data_nx_s;
    logic             hold_release_s;
    logic             guard_release_s;

`ifdef MUX_LAUNCH_ACK_EN
    logic ack_s;

    sync_2ff u_ack_sync (
        .clk (clka),
        .rst (rsta),
        .d   (ack_b),
        .q   (ack_s)
    );

    assign hold_release_s  = ack_s;
    assign guard_release_s = ~ack_s;
`else
    assign hold_release_s  = 1'b1;
    assign guard_release_s = 1'b1;
`endif

    // Ready is a pure function of state, masked while reset is asserted.
    assign in_ready = (state_r == IDLE) & ~rsta;

    // Next-state, counter, en and data decode.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        en_nx_s    = en;
        data_nx_s  = data;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_nx_s  = in_data;
                    en_nx_s    = 1'b1;
                    cnt_nx_s   = HOLD_LD;
                    state_nx_s = HOLD;
                end else begin
                    en_nx_s    = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_r != '0) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else if (hold_release_s) begin
                    en_nx_s = 1'b0;
                    if (GUARD_CYCLES == 0) begin
                        cnt_nx_s   = '0;
                        state_nx_s = IDLE;
                    end else begin
                        cnt_nx_s   = GUARD_LD;
                        state_nx_s = GUARD;
                    end
                end else begin
                    // waiting for the destination acknowledge
                    en_nx_s = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_r != '0) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else if (guard_release_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = GUARD;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
                en_nx_s    = 1'b0;
            end
        endcase
    end

    // State, counter and all synchronizer-facing outputs are flops.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            en      <= 1'b0;
            data    <= '0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            en      <= en_nx_s;
            data    <= data_nx_s;
            busy    <= (state_nx_s != IDLE);
        end
    end

endmodule

// File: doc/mux_sync_launcher.md
Name: mux_sync_launcher

Overview:
- Source-domain (clka) stage directly upstream of the mux-recirculation N-flop synchronizer.
- Accepts words from clka logic over a valid/ready handshake and drives the synchronizer's en/data pair.
- Holds data stable around a stretched en pulse long enough for the slower clkb domain to sample it safely.
- Guarantees that data never changes while en, or its synchronized copy, may still be in flight.

Parameters:
- DW, 8, data width.
- HOLD_CYCLES, 9, clka cycles en stays high. Must be >=1. The default covers 3 clkb periods at the 1:3 clka:clkb ratio.
- GUARD_CYCLES, 6, clka cycles data stays frozen after en falls. Must be >=0; 0 means return straight to IDLE.
- CNT_W, $clog2(max(HOLD_CYCLES,GUARD_CYCLES)+1), counter width. Derived; do not override.

Ports:
- clka  in  1  clock (source domain)
- rsta  in  1  reset; asynchronous, active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  launcher can accept
- in_data  in  DW  upstream word
- en  out  1  enable to synchronizer, registered
- data  out  DW  data to synchronizer, registered
- busy  out  1  state != IDLE
- ack_b  in  1  destination acknowledge level (clkb domain). Present only with MUX_LAUNCH_ACK_EN.

Behaviour:
- Reset values (rsta high): state=IDLE, en=0, data=0, cnt=0, busy=0, in_ready=0.
  - in_ready is forced 0 while rsta is high.
  - After release, in_ready=1 combinationally in IDLE.
- in_ready = (state==IDLE) & ~rsta. It is combinational from state only and never depends on in_valid.
- IDLE: on the edge where in_valid&in_ready:
  - data<=in_data, en<=1, cnt<=HOLD_CYCLES-1, state<=HOLD.
  - In_valid without ready is ignored; upstream must hold it.
- HOLD: en=1, data frozen.
  - If cnt!=0: cnt decrements.
  - If cnt==0: en<=0 and state<=GUARD with cnt<=GUARD_CYCLES-1, or state<=IDLE if GUARD_CYCLES==0.
  - en is high for exactly HOLD_CYCLES clka cycles.
- GUARD: en=0, data frozen.
  - If cnt!=0: cnt decrements.
  - If cnt==0: state<=IDLE.
- data keeps its last value in IDLE. It changes only on an accept edge.
- Latency: first en-high cycle is 1 cycle after the accept edge.
- Minimum accept-to-accept spacing: 1+HOLD_CYCLES+GUARD_CYCLES cycles (16 at defaults).
- Back-to-back: in_valid held high continuously yields one accept per spacing period. No word is dropped or duplicated.
- Reset mid-operation: en drops to 0 and data to 0 immediately (asynchronous). The in-flight word is discarded and the state returns to IDLE.
- en and data are both flop outputs in clka. There is no combinational path from in_* to en or data.

Optional Feature:
MUX_LAUNCH_ACK_EN
- Defined:
  - ack_b is synchronized into clka through a 2-flop synchronizer (ack_s).
  - HOLD exits only when cnt==0 AND ack_s==1; en stays high until the destination is seen to acknowledge.
  - GUARD exits only when cnt==0 AND ack_s==0; this completes a 4-phase handshake.
  - ack_s resets to 0.
- Undefined: the port is absent and timing is purely count-based, as above.

Decomposition:
- Shared package mux_sync_pkg holds:
  - state enum typedef (IDLE=2'd0, HOLD=2'd1, GUARD=2'd2);
  - default DW, HOLD_CYCLES and GUARD_CYCLES constants, so the synchronizer and its benches agree.
- One sub-module: sync_2ff (1-bit, clk, async active-high rst, reset 0).
  - Instantiated only under MUX_LAUNCH_ACK_EN.
  - Reusable by the destination side.

Test Plan:
- Reset: rsta=1 for 2ns -> en=0, data=8'h00, in_ready=0, busy=0. After release, in_ready=1 on the same cycle.
- Single word: in_data=8'h55, in_valid one cycle -> data=8'h55 and en=1 from the next edge for exactly 9 cycles. Then 6 cycles of en=0 with data=8'h55, then in_ready=1.
- Back-to-back: in_valid held, in_data 8'hFF then 8'hAC -> accepts exactly 16 cycles apart. data never changes while en=1 or during GUARD.
- Stall: in_valid=1 while busy -> no accept and in_ready=0. data still equals the previous word until IDLE.
- Mid-HOLD reset: assert rsta at HOLD cycle 4 -> en=0 and data=8'h00 asynchronously. The next word after release is accepted normally.
- With MUX_LAUNCH_ACK_EN: ack_b rises 20ns after en rises -> en stays high until 2 clka cycles after ack_b. GUARD ends only after ack_b falls plus sync delay, and no earlier than the GUARD count.
